// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared definitions for the shift sequencer: FSM state
//               encoding, per-step shift distances and default widths.
//               The optional right-shift build is enabled by defining
//               SHIFT_SEQ_RIGHT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

  // Default operand width and shift-amount width.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_AMT_W = 4;

  // Distances covered by one coarse and one fine shift step.
  localparam int STEP_BIG   = 4;
  localparam int STEP_SMALL = 1;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  // Number of bit positions one step consumes.
  function automatic int step_len(input logic big);
    return big ? STEP_BIG : STEP_SMALL;
  endfunction

endpackage : shift_pkg

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module      : shift_step
// Description : Combinational single-step shifter. Moves the value by either
//               STEP_BIG or STEP_SMALL positions, left or logical right, with
//               zero fill. Bits moved past either end are discarded.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   value    in  WIDTH  value to shift
//   big      in  1      1 = coarse step (STEP_BIG), 0 = fine step (STEP_SMALL)
//   dir      in  1      0 = left, 1 = logical right
//   shifted  out WIDTH  shifted value
// ============================================================================
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             big,
  input  logic             dir,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;

  always_comb begin
    w_left  = big ? (value << STEP_BIG) : (value << STEP_SMALL);
    w_right = big ? (value >> STEP_BIG) : (value >> STEP_SMALL);
    shifted = dir ? w_right : w_left;
  end

endmodule : shift_step

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle barrel-free shifter. An accepted start loads the
//               operand and shift amount, then one step per cycle shifts by
//               4 while at least 4 positions remain, otherwise by 1. A
//               one-cycle done pulse marks the result. Starts arriving while
//               busy (including the done cycle) are ignored.
//               Optional build: define SHIFT_SEQ_RIGHT_EN to add the dir
//               port selecting a logical right shift.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in  1      clock, rising edge
//   reset  in  1      asynchronous active-high reset
//   start  in  1      shift request, accepted only while idle
//   a      in  WIDTH  operand, sampled on accepted start
//   amt    in  AMT_W  shift amount, sampled on accepted start
//   dir    in  1      (SHIFT_SEQ_RIGHT_EN only) 0 = left, 1 = logical right
//   busy   out 1      high while shifting or presenting the result
//   done   out 1      one-cycle pulse, r holds the finished result
//   r      out WIDTH  result register, held while idle
// ============================================================================
`default_nettype none

module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
`ifdef SHIFT_SEQ_RIGHT_EN
  input  logic             dir,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r
);

  // State encodings mirrored from the package enum as plain constants.
  localparam logic [1:0] c_st_idle  = IDLE;
  localparam logic [1:0] c_st_shift = SHIFT;
  localparam logic [1:0] c_st_done  = DONE;

  logic [1:0]       r_state;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;

  logic             w_big;
  logic [AMT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_stepped;
  logic             w_dir;

`ifdef SHIFT_SEQ_RIGHT_EN
  // Direction is captured with the operand so a change on the input pin
  // mid-operation cannot flip the shift direction.
  logic r_dir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dir <= 1'b0;
    end else if (r_state == c_st_idle && start) begin
      r_dir <= dir;
    end
  end

  assign w_dir = r_dir;
`else
  assign w_dir = 1'b0;
`endif

  // Coarse step whenever at least STEP_BIG positions remain. The count is
  // widened before comparing so the test stays correct for narrow AMT_W.
  assign w_big      = (32'(r_cnt) >= 32'(STEP_BIG));
  assign w_cnt_next = r_cnt - AMT_W'(step_len(w_big));

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .value   (r_result),
    .big     (w_big),
    .dir     (w_dir),
    .shifted (w_stepped)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= c_st_idle;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_result <= a;
            r_cnt    <= amt;
            // A zero amount has nothing to shift: go straight to DONE.
            r_state  <= (amt != '0) ? c_st_shift : c_st_done;
          end
        end
        c_st_shift: begin
          r_result <= w_stepped;
          r_cnt    <= w_cnt_next;
          // Leave on the step that consumes the last position, so no
          // idle SHIFT cycle with a zero count is ever spent.
          if (w_cnt_next == '0) begin
            r_state <= c_st_done;
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign busy = (r_state != c_st_idle);
  assign done = (r_state == c_st_done);
  assign r    = r_result;

endmodule : shift_sequencer

`default_nettype wire
